sum_nb_serial: RTL and testbench

Parametrised, multi-cycle successor to the team's fixed 4-bit ripple adder. It adds or subtracts two WIDTH-bit operands one CHUNK-bit slice per clock, with a registered carry chained between slices, under a start/busy/done handshake. Outputs are signed overflow, carry-out and the full sum. It is the arithmetic building block for the datapath labs, where area matters more than single-cycle latency.

---
 rtl/sum_nb_serial.sv | 110 +++++++++++
 tb/tb_sum_nb_serial.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/sum_nb_serial.sv
// Chunk-serial add/subtract unit: one CHUNK-bit slice per clock with a registered carry.
// Results (Sum/Cout/Ovf) update only on the completion edge, flagged by a one-cycle done pulse.
module sum_nb_serial #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [KW-1:0]    k_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q, bx_q, acc_q, acc_d;
  logic [CHUNK-1:0] a_sl, b_sl;
  logic [CHUNK:0]   sl_sum;
  logic             last, msb_cin;
  int               base;

  function automatic logic [CHUNK:0] slice_add(input logic [CHUNK-1:0] a,
                                               input logic [CHUNK-1:0] b,
                                               input logic             c);
    return {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, c};
  endfunction

  assign busy = (state_q == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Slice datapath and next-state logic; the carry into the MSB is recovered from
  // the MSB sum bit, so signed overflow needs no extra adder.
  always_comb begin
    state_d = state_q;
    base    = int'(k_q) * CHUNK;
    a_sl    = a_q[base +: CHUNK];
    b_sl    = bx_q[base +: CHUNK];
    sl_sum  = slice_add(a_sl, b_sl, carry_q);
    last    = (k_q == KW'(NCH - 1));
    msb_cin = sl_sum[CHUNK-1] ^ a_sl[CHUNK-1] ^ b_sl[CHUNK-1];
    acc_d   = acc_q;
    acc_d[base +: CHUNK] = sl_sum[CHUNK-1:0];
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture: pure data, no reset needed.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && start) begin
      a_q  <= A;
      bx_q <= Op ? ~B : B;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q     <= '0;
      carry_q <= 1'b0;
      acc_q   <= '0;
      done    <= 1'b0;
      Sum     <= '0;
      Cout    <= 1'b0;
      Ovf     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            k_q     <= '0;
            carry_q <= Ci ^ Op;
            acc_q   <= '0;
          end
        end
        RUN: begin
          acc_q   <= acc_d;
          carry_q <= sl_sum[CHUNK];
          k_q     <= k_q + KW'(1);
          if (last) begin
            Sum  <= acc_d;
            Cout <= sl_sum[CHUNK];
            Ovf  <= msb_cin ^ sl_sum[CHUNK];
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sum_nb_serial.sv
// Directed bench for sum_nb_serial: table of hand-computed add/subtract vectors,
// handshake and reset corner cases, and CHUNK=16 / CHUNK=1 instances against a model.
module tb_sum_nb_serial;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        Op, Ci;
  logic [15:0] A, B;
  logic        st0, st16, st1;

  logic        busy0, done0, cout0, ovf0;
  logic [15:0] sum0;
  logic        busy16, done16, cout16, ovf16;
  logic [15:0] sum16;
  logic        busy1, done1, cout1, ovf1;
  logic [15:0] sum1;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  sum_nb_serial #(.WIDTH(16), .CHUNK(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(st0), .Op(Op), .A(A), .B(B), .Ci(Ci),
    .busy(busy0), .done(done0), .Sum(sum0), .Cout(cout0), .Ovf(ovf0));

  sum_nb_serial #(.WIDTH(16), .CHUNK(16)) u_c16 (
    .clk(clk), .rst_n(rst_n), .start(st16), .Op(Op), .A(A), .B(B), .Ci(Ci),
    .busy(busy16), .done(done16), .Sum(sum16), .Cout(cout16), .Ovf(ovf16));

  sum_nb_serial #(.WIDTH(16), .CHUNK(1)) u_c1 (
    .clk(clk), .rst_n(rst_n), .start(st1), .Op(Op), .A(A), .B(B), .Ci(Ci),
    .busy(busy1), .done(done1), .Sum(sum1), .Cout(cout1), .Ovf(ovf1));

  always @(negedge clk) if (done0) done_cnt++;

  typedef struct {
    logic [15:0] a, b;
    logic        op, ci;
    logic [15:0] sum;
    logic        cout, ovf;
  } vec_t;

  vec_t vt[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic sel_done(input int w);
    return (w == 0) ? done0 : (w == 1) ? done16 : done1;
  endfunction

  function automatic logic [17:0] sel_res(input int w);
    if (w == 0) return {cout0, ovf0, sum0};
    if (w == 1) return {cout16, ovf16, sum16};
    return {cout1, ovf1, sum1};
  endfunction

  // Reference: {cout, ovf, sum} from a 17-bit add and sign comparison
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic op, input logic ci);
    logic [15:0] bx;
    logic [16:0] full;
    logic        ov;
    bx   = op ? ~b : b;
    full = {1'b0, a} + {1'b0, bx} + {16'd0, ci ^ op};
    ov   = (a[15] == bx[15]) && (full[15] != a[15]);
    return {full[16], ov, full[15:0]};
  endfunction

  task automatic run_op(input int w, input logic [15:0] a, input logic [15:0] b,
                        input logic op, input logic ci, output int lat);
    @(negedge clk);
    A = a; B = b; Op = op; Ci = ci;
    st0 = (w == 0); st16 = (w == 1); st1 = (w == 2);
    @(posedge clk); #1;
    st0 = 1'b0; st16 = 1'b0; st1 = 1'b0;
    lat = 0;
    while (!sel_done(w) && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    int          snap;
    logic [17:0] res, exp;
    logic [15:0] ra, rb;
    logic        rop, rci;

    vt[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
    vt[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vt[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vt[3] = '{16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0};
    vt[4] = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    vt[5] = '{16'h0005, 16'h0002, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0};
    vt[6] = '{16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0};
    vt[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};

    // Reset held with random inputs
    rst_n = 1'b0;
    A = 16'($urandom); B = 16'($urandom); Op = 1'($urandom); Ci = 1'($urandom);
    st0 = 1'($urandom); st16 = 1'b0; st1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy0, 0);
    check("reset_done", done0, 0);
    check("reset_sum",  sum0,  0);
    check("reset_cout", cout0, 0);
    check("reset_ovf",  ovf0,  0);
    @(negedge clk);
    st0 = 1'b0;
    rst_n = 1'b1;

    foreach (vt[i]) begin
      run_op(0, vt[i].a, vt[i].b, vt[i].op, vt[i].ci, lat);
      check($sformatf("vec%0d_latency", i), lat, 4);
      check($sformatf("vec%0d_sum", i),  sum0,  vt[i].sum);
      check($sformatf("vec%0d_cout", i), cout0, vt[i].cout);
      check($sformatf("vec%0d_ovf", i),  ovf0,  vt[i].ovf);
    end

    // busy right after the start edge, done drops the cycle after it pulses
    @(negedge clk);
    A = 16'h00FF; B = 16'h0001; Op = 1'b0; Ci = 1'b0; st0 = 1'b1;
    @(posedge clk); #1;
    st0 = 1'b0;
    check("busy_after_start", busy0, 1);
    check("sum_not_partial", sum0, 16'h0000);
    // second start while busy must be ignored
    snap = done_cnt;
    repeat (2) @(posedge clk);
    @(negedge clk);
    A = 16'h1234; B = 16'h1111; st0 = 1'b1;
    @(posedge clk); #1;
    st0 = 1'b0;
    lat = 3;
    while (!done0 && lat < 40) begin @(posedge clk); #1; lat++; end
    check("ignored_start_latency", lat, 4);
    check("ignored_start_sum", sum0, 16'h0100);
    @(posedge clk); #1;
    check("done_one_cycle", done0, 0);
    repeat (5) @(posedge clk);
    #1;
    check("single_done_pulse", done_cnt - snap, 1);
    check("sum_holds", sum0, 16'h0100);

    // start raised in the done cycle is accepted
    run_op(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, lat);
    check("b2b_first_done", done0, 1);
    A = 16'h0005; B = 16'h0007; Op = 1'b1; Ci = 1'b0; st0 = 1'b1;
    @(posedge clk); #1;
    st0 = 1'b0;
    check("b2b_busy", busy0, 1);
    lat = 0;
    while (!done0 && lat < 40) begin @(posedge clk); #1; lat++; end
    check("b2b_latency", lat, 4);
    check("b2b_sum", sum0, 16'hFFFE);

    // asynchronous reset in the middle of an operation
    @(negedge clk);
    A = 16'h1234; B = 16'h1111; Op = 1'b0; Ci = 1'b0; st0 = 1'b1;
    @(posedge clk); #1;
    st0 = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", busy0, 0);
    check("async_rst_sum",  sum0,  0);
    check("async_rst_cout", cout0, 0);
    snap = done_cnt;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt - snap, 0);
    check("abort_sum_zero", sum0, 0);
    run_op(0, 16'h1234, 16'h1111, 1'b0, 1'b0, lat);
    check("after_abort_latency", lat, 4);
    check("after_abort_sum", sum0, 16'h2345);

    // CHUNK=16 and CHUNK=1 instances against the reference model
    for (int w = 1; w <= 2; w++) begin
      for (int n = 0; n < 8; n++) begin
        ra = 16'($urandom); rb = 16'($urandom); rop = 1'($urandom); rci = 1'($urandom);
        if (n == 0) begin ra = 16'h7FFF; rb = 16'h0001; rop = 1'b0; rci = 1'b0; end
        if (n == 1) begin ra = 16'h8000; rb = 16'h0001; rop = 1'b1; rci = 1'b0; end
        exp = model(ra, rb, rop, rci);
        run_op(w, ra, rb, rop, rci, lat);
        res = sel_res(w);
        check($sformatf("sweep%0d_%0d_latency", w, n), lat, (w == 1) ? 1 : 16);
        check($sformatf("sweep%0d_%0d_sum", w, n),  res[15:0], exp[15:0]);
        check($sformatf("sweep%0d_%0d_cout", w, n), res[17],   exp[17]);
        check($sformatf("sweep%0d_%0d_ovf", w, n),  res[16],   exp[16]);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
